lfsr_seq_ctrl: RTL and testbench
================================

# lfsr_seq_ctrl

Sequencer for the pseudo-random stimulus LFSR that feeds the systolic array test path. It accepts a configuration (seed, stop code, maximum length) over a valid/ready handshake and loads and steps one `lfsr` instance. It presents the LFSR words as a valid/ready stream with a last marker, then reports completion, the word count and the termination cause.

## Interface
Parameters:
- `NUM_BITS`, default 49: LFSR and stream data width. The taps are fixed for 49.
- `CNT_W`, default 16: width of the length field and the word counter.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_cfg_vld`, in, 1: configuration valid.
- `o_cfg_rdy`, out, 1: configuration ready. High only in IDLE.
- `i_cfg_seed`, in, NUM_BITS: first word of the sequence.
- `i_cfg_stop`, in, NUM_BITS: stop code. The word equal to it is the final word.
- `i_cfg_len`, in, CNT_W: maximum word count. 0 means emit nothing.
- `i_abort`, in, 1: terminate the current stream.
- `o_vld`, out, 1: stream data valid.
- `i_rdy`, in, 1: stream ready from the consumer.
- `o_data`, out, NUM_BITS: current LFSR word.
- `o_last`, out, 1: marks the final word. Qualified by `o_vld`.
- `o_busy`, out, 1: high while not in IDLE.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_cause`, out, 2: termination cause. 0 = length, 1 = stop code, 2 = abort. Valid from `o_done` until the next accept.
- `o_count`, out, CNT_W: words transferred. Held from `o_done` until the next accept.

## Operation
- States: IDLE, STREAM, DONE.
- All outputs reset to 0. The state resets to IDLE. The internal LFSR register resets to 0.
- **IDLE:**
  - `o_cfg_rdy` = 1.
  - Accept occurs when `i_cfg_vld` and `o_cfg_rdy` are both high. On accept:
    - capture the stop code and the length;
    - clear `o_count` and `o_cause`;
    - drive the LFSR with en=1, load=1, data=`i_cfg_seed` in the same cycle.
  - Next state: STREAM if len ≠ 0. Otherwise DONE with cause 0 and count 0.
- **STREAM:**
  - `o_vld` = 1 and `o_data` = the LFSR register.
  - `o_last` = (count == len−1) OR (`o_data` == captured stop).
  - On a handshake (`o_vld` and `i_rdy` both high):
    - count increments;
    - if `o_last` is high, go to DONE with cause 1 if the stop code matched, else cause 0;
    - otherwise step the LFSR (en=1, load=0).
  - Without a handshake: the LFSR is not enabled, so `o_data` and `o_last` hold stable.
- **Abort:**
  - If `i_abort` is high in STREAM, go to DONE with cause 2. The LFSR is not stepped.
  - If abort coincides with a handshake, the word counts as transferred.
  - If abort coincides with a handshake on the last word, the last-word cause wins.
  - `i_abort` is ignored in IDLE and DONE.
- **Stop priority:** when the stop match and the length limit coincide, cause = 1. A seed equal to the stop code gives exactly one word.
- **DONE:** `o_done` = 1 for one cycle, then IDLE. `o_cfg_rdy` = 0 in DONE.
- **LFSR step rule:** new word = {old[NUM_BITS-2:0], ~(old[48] ^ old[39])}.
  - The all-ones seed is the lockup state and repeats forever. The length limit still terminates it.
- **Counter:** `o_count` saturates at 2^CNT_W−1. It cannot overflow because len ≤ 2^CNT_W−1.
- **Reset mid-stream:** `o_vld`, `o_busy` and `o_done` drop asynchronously. No `o_done` is produced.

## Timing
- Accept in cycle T → first word valid in cycle T+1. Single-cycle latency.
- Throughput: one word per cycle while `i_rdy` = 1. There are no bubbles between words.
- Last handshake in cycle L → `o_done` in L+1 → `o_cfg_rdy` = 1 in L+2.
- Abort sampled in cycle A → `o_vld` = 0 and `o_done` = 1 in A+1.
- Configuration input with len=0 accepted in T → `o_done` in T+1. `o_vld` never rises.
- `o_data`, `o_last` and `o_vld` come directly from registers plus the stop comparator. No combinational path runs from `i_rdy` to `o_vld`.

## Structure
- Shared package `lfsr_seq_pkg`:
  - state enum `seq_state_e` (IDLE, STREAM, DONE);
  - cause enum `seq_cause_e` (CAUSE_LEN=0, CAUSE_STOP=1, CAUSE_ABORT=2).
- Sub-module: one `lfsr` instance with `NUM_BITS`=49.
  - Its active-high reset is driven by ~`i_rst_n`.
  - Its done output is used as the stop match. Its valid output is unused.
  - Its stop-code input is the captured stop register.

## Test plan
- Seed 1, stop 0, len 4, `i_rdy`=1:
  - words 0x1, 0x3, 0x7, 0xF in T+1..T+4;
  - `o_last` on 0xF;
  - `o_done` at T+5 with cause 0 and count 4.
- Seed 1, stop 0x7, len 100: three words (0x1, 0x3, 0x7), last on 0x7, cause 1, count 3.
- Seed 1, stop 0, len 4, with `i_rdy` pattern 1,0,0,1,0,1,1:
  - `o_data` and `o_last` hold during stalls;
  - the same four words are transferred;
  - count 4.
- Seed 1, len 10, `i_abort` at the third word's handshake: count 3, no `o_last` seen, cause 2, `o_vld` low the next cycle.
- len 0: accept → `o_done` next cycle, cause 0, count 0, `o_vld` never high. Seed = stop with len 5: one word with `o_last`, cause 1.
- `i_rst_n` pulsed low mid-stream: all outputs 0 immediately. After release, `o_cfg_rdy`=1 and a new configuration produces the correct sequence from its seed.

Source files
------------

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types for the LFSR stimulus sequencer: FSM states, termination causes
// and the fixed feedback taps of the 49-bit generator.
package lfsr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_LEN   = 2'd0,
        CAUSE_STOP  = 2'd1,
        CAUSE_ABORT = 2'd2
    } seq_cause_e;

    localparam int LFSR_TAP_HI = 48;
    localparam int LFSR_TAP_LO = 39;

endpackage

// File: rtl/lfsr_seq_ctrl_lfsr.sv
// Loadable 49-bit XNOR Fibonacci LFSR with a combinational stop-code compare.
// The all-ones word is the lockup state and maps onto itself.
module lfsr
    import lfsr_seq_pkg::*;
#(
    parameter int NUM_BITS = 49
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_load,
    input  logic [NUM_BITS-1:0] i_data,
    input  logic [NUM_BITS-1:0] i_stop,
    output logic [NUM_BITS-1:0] o_data,
    output logic                o_vld,
    output logic                o_done
);

    logic [NUM_BITS-1:0] r_data;
    logic                r_vld;
    logic                w_feedback;

    assign w_feedback = ~(r_data[LFSR_TAP_HI] ^ r_data[LFSR_TAP_LO]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (i_en) begin
            r_data <= i_load ? i_data : {r_data[NUM_BITS-2:0], w_feedback};
            r_vld  <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
    assign o_done = (r_data == i_stop);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer: accepts seed/stop/length, streams LFSR words over valid/ready with a
// last marker, then pulses done with the word count and termination cause.
module lfsr_seq_ctrl
    import lfsr_seq_pkg::*;
#(
    parameter int NUM_BITS = 49,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cfg_vld,
    output logic                o_cfg_rdy,
    input  logic [NUM_BITS-1:0] i_cfg_seed,
    input  logic [NUM_BITS-1:0] i_cfg_stop,
    input  logic [CNT_W-1:0]    i_cfg_len,
    input  logic                i_abort,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic [NUM_BITS-1:0] o_data,
    output logic                o_last,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_cause,
    output logic [CNT_W-1:0]    o_count
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never depends combinationally on ready.
    seq_state_e          r_state;
    seq_cause_e          r_cause;
    logic [NUM_BITS-1:0] r_stop;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_count;
    logic                r_cfg_rdy;
    logic                r_vld;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_hs;
    logic                w_stop_hit;
    logic                w_len_hit;
    logic                w_last;
    logic                w_lfsr_en;
    logic                w_lfsr_vld_unused;
    logic [NUM_BITS-1:0] w_lfsr_data;
    logic [CNT_W-1:0]    w_count_inc;

    assign w_accept    = r_cfg_rdy & i_cfg_vld;
    assign w_hs        = r_vld & i_rdy;
    assign w_len_hit   = (r_count == (r_len - CNT_W'(1)));
    assign w_last      = r_vld & (w_len_hit | w_stop_hit);
    assign w_lfsr_en   = w_accept | (w_hs & ~w_last & ~i_abort);
    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

    lfsr #(
        .NUM_BITS (NUM_BITS)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (~i_rst_n),
        .i_en   (w_lfsr_en),
        .i_load (w_accept),
        .i_data (i_cfg_seed),
        .i_stop (r_stop),
        .o_data (w_lfsr_data),
        .o_vld  (w_lfsr_vld_unused),
        .o_done (w_stop_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cause   <= CAUSE_LEN;
            r_stop    <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_cfg_rdy <= 1'b0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_stop    <= i_cfg_stop;
                        r_len     <= i_cfg_len;
                        r_count   <= '0;
                        r_cause   <= CAUSE_LEN;
                        r_cfg_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        if (i_cfg_len != '0) begin
                            r_state <= STREAM;
                            r_vld   <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cfg_rdy <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_hs) begin
                        r_count <= w_count_inc;
                    end
                    // A last-word handshake outranks a simultaneous abort.
                    if (w_hs && w_last) begin
                        r_state <= DONE;
                        r_cause <= w_stop_hit ? CAUSE_STOP : CAUSE_LEN;
                        r_vld   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (i_abort) begin
                        r_state <= DONE;
                        r_cause <= CAUSE_ABORT;
                        r_vld   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_cfg_rdy <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_vld     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_cfg_rdy <= 1'b0;
                end
            endcase
        end
    end

    assign o_cfg_rdy = r_cfg_rdy;
    assign o_vld     = r_vld;
    assign o_data    = w_lfsr_data;
    assign o_last    = w_last;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_cause   = r_cause;
    assign o_count   = r_count;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with hand-computed LFSR words.
module tb_lfsr_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_vld;
    logic        cfg_rdy;
    logic [48:0] cfg_seed;
    logic [48:0] cfg_stop;
    logic [15:0] cfg_len;
    logic        abort;
    logic        vld;
    logic        rdy;
    logic [48:0] data;
    logic        last;
    logic        busy;
    logic        done;
    logic [1:0]  cause;
    logic [15:0] count;

    int n_assert;
    int n_fail;

    lfsr_seq_ctrl #(.NUM_BITS(49), .CNT_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cfg_vld  (cfg_vld),
        .o_cfg_rdy  (cfg_rdy),
        .i_cfg_seed (cfg_seed),
        .i_cfg_stop (cfg_stop),
        .i_cfg_len  (cfg_len),
        .i_abort    (abort),
        .o_vld      (vld),
        .i_rdy      (rdy),
        .o_data     (data),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done),
        .o_cause    (cause),
        .o_count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cfg(input logic [48:0] seed, input logic [48:0] stop, input logic [15:0] len);
        chk("cfg_rdy_before_accept", 64'(cfg_rdy), 64'd1);
        cfg_vld  = 1'b1;
        cfg_seed = seed;
        cfg_stop = stop;
        cfg_len  = len;
        tick();
        cfg_vld  = 1'b0;
    endtask

    task automatic expect_word(input logic [48:0] w, input logic l);
        chk("stream_vld", 64'(vld), 64'd1);
        chk("stream_data", 64'(data), 64'(w));
        chk("stream_last", 64'(last), 64'(l));
    endtask

    task automatic finish_chk(input logic [1:0] c, input logic [15:0] n);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_vld_low", 64'(vld), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_cfg_rdy_low", 64'(cfg_rdy), 64'd0);
        chk("done_cause", 64'(cause), 64'(c));
        chk("done_count", 64'(count), 64'(n));
        tick();
        chk("idle_done_low", 64'(done), 64'd0);
        chk("idle_cfg_rdy", 64'(cfg_rdy), 64'd1);
        chk("idle_busy_low", 64'(busy), 64'd0);
        chk("idle_cause_held", 64'(cause), 64'(c));
        chk("idle_count_held", 64'(count), 64'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 64'(vld), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cfg_rdy"}, 64'(cfg_rdy), 64'd0);
        chk({tag, "_last"}, 64'(last), 64'd0);
        chk({tag, "_data"}, 64'(data), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_cause"}, 64'(cause), 64'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        cfg_vld  = 1'b0;
        cfg_seed = '0;
        cfg_stop = '0;
        cfg_len  = '0;
        abort    = 1'b0;
        rdy      = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("post_reset_cfg_rdy", 64'(cfg_rdy), 64'd1);

        // Length-terminated run, consumer always ready
        rdy = 1'b1;
        start_cfg(49'h1, 49'h0, 16'd4);
        expect_word(49'h1, 1'b0);
        tick();
        expect_word(49'h3, 1'b0);
        tick();
        expect_word(49'h7, 1'b0);
        tick();
        expect_word(49'hF, 1'b1);
        tick();
        finish_chk(2'd0, 16'd4);

        // Stop-code terminated run
        start_cfg(49'h1, 49'h7, 16'd100);
        expect_word(49'h1, 1'b0);
        tick();
        expect_word(49'h3, 1'b0);
        tick();
        expect_word(49'h7, 1'b1);
        tick();
        finish_chk(2'd1, 16'd3);

        // Back-pressure pattern 1,0,0,1,0,1,1
        rdy = 1'b1;
        start_cfg(49'h1, 49'h0, 16'd4);
        expect_word(49'h1, 1'b0);
        tick();
        rdy = 1'b0;
        expect_word(49'h3, 1'b0);
        tick();
        expect_word(49'h3, 1'b0);
        tick();
        rdy = 1'b1;
        expect_word(49'h3, 1'b0);
        tick();
        rdy = 1'b0;
        expect_word(49'h7, 1'b0);
        tick();
        rdy = 1'b1;
        expect_word(49'h7, 1'b0);
        tick();
        expect_word(49'hF, 1'b1);
        tick();
        finish_chk(2'd0, 16'd4);

        // Abort coinciding with the third handshake
        start_cfg(49'h1, 49'h0, 16'd10);
        expect_word(49'h1, 1'b0);
        tick();
        expect_word(49'h3, 1'b0);
        tick();
        expect_word(49'h7, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        finish_chk(2'd2, 16'd3);

        // Zero length emits nothing
        start_cfg(49'h1, 49'h0, 16'd0);
        finish_chk(2'd0, 16'd0);

        // Seed equal to stop gives one word
        start_cfg(49'h1234, 49'h1234, 16'd5);
        expect_word(49'h1234, 1'b1);
        tick();
        finish_chk(2'd1, 16'd1);

        // Stop match and length limit on the same word: stop wins
        start_cfg(49'h1, 49'h7, 16'd3);
        expect_word(49'h1, 1'b0);
        tick();
        expect_word(49'h3, 1'b0);
        tick();
        expect_word(49'h7, 1'b1);
        tick();
        finish_chk(2'd1, 16'd3);

        // All-ones lockup word repeats; length terminates
        start_cfg({49{1'b1}}, 49'h0, 16'd3);
        expect_word({49{1'b1}}, 1'b0);
        tick();
        expect_word({49{1'b1}}, 1'b0);
        tick();
        expect_word({49{1'b1}}, 1'b1);
        tick();
        finish_chk(2'd0, 16'd3);

        // Tap 48 alone: shifts out, feedback 0, reaches stop code 0 at the length limit
        start_cfg(49'h1_0000_0000_0000, 49'h0, 16'd2);
        expect_word(49'h1_0000_0000_0000, 1'b0);
        tick();
        expect_word(49'h0, 1'b1);
        tick();
        finish_chk(2'd1, 16'd2);

        // Tap 39 alone: feedback 0
        start_cfg(49'h0_0080_0000_0000, 49'h0, 16'd2);
        expect_word(49'h0_0080_0000_0000, 1'b0);
        tick();
        expect_word(49'h0_0100_0000_0000, 1'b1);
        tick();
        finish_chk(2'd0, 16'd2);

        // Asynchronous reset mid-stream
        start_cfg(49'h1, 49'h0, 16'd10);
        expect_word(49'h1, 1'b0);
        tick();
        expect_word(49'h3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        chk("reset_held_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rerelease_cfg_rdy", 64'(cfg_rdy), 64'd1);
        start_cfg(49'h5, 49'h0, 16'd3);
        expect_word(49'h5, 1'b0);
        tick();
        expect_word(49'hB, 1'b0);
        tick();
        expect_word(49'h17, 1'b1);
        tick();
        finish_chk(2'd0, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
